lsu: RTL and testbench

Load/store unit forming the memory-access/write-back stage directly downstream of `ex`. Accepts one retired `ex` result per transaction. Passes ALU results straight to the register-file write port. For loads and stores, runs a request/acknowledge transaction on the data-memory bus, then aligns and extends load data before writing it back. While a memory transaction is outstanding it stalls the front end through `pause`.

---
 rtl/lsu.sv | 197 +++++++++++++++++++
 tb/tb_lsu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Memory-access / write-back stage: forwards ALU results to the register file and runs
// one request/acknowledge data-memory transaction per load or store.
module lsu #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ex_valid_i,
   output logic            ex_ready_o,
   input  logic            ex_load_i,
   input  logic            ex_store_i,
   input  logic [2:0]      ex_funct3_i,
   input  logic [XLEN-1:0] ex_result_i,
   input  logic [XLEN-1:0] ex_wdata_i,
   input  logic [4:0]      ex_rd_i,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [3:0]      mem_wstrb_o,
   input  logic            mem_ack_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            regs_write_en_o,
   output logic [4:0]      regs_write_addr_o,
   output logic [XLEN-1:0] regs_in_o,
   output logic            pause_o,
   output logic            fault_o
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic              wr_en_q, wr_en_d;
   logic [4:0]        wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]   wr_data_q, wr_data_d;
   logic              fault_q, fault_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d;

   logic              legal, aligned;
   logic [3:0]        st_wstrb;
   logic [XLEN-1:0]   st_wdata;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [XLEN-1:0]   ld_data;

   // Access legality and alignment of the op presented by ex
   always_comb begin
      legal = 1'b0;
      if (ex_load_i && !ex_store_i) begin
         legal = (ex_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end else if (ex_store_i && !ex_load_i) begin
         legal = (ex_funct3_i inside {3'b000, 3'b001, 3'b010});
      end
      unique case (ex_funct3_i[1:0])
         2'b01:   aligned = !ex_result_i[0];
         2'b10:   aligned = (ex_result_i[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   always_comb begin
      unique case (ex_funct3_i[1:0])
         2'b00: begin
            st_wstrb = 4'b0001 << ex_result_i[1:0];
            st_wdata = {4{ex_wdata_i[7:0]}};
         end
         2'b01: begin
            st_wstrb = 4'b0011 << ex_result_i[1:0];
            st_wdata = {2{ex_wdata_i[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = ex_wdata_i;
         end
      endcase
   end

   always_comb begin
      unique case (off_q)
         2'd0: ld_byte = mem_rdata_i[7:0];
         2'd1: ld_byte = mem_rdata_i[15:8];
         2'd2: ld_byte = mem_rdata_i[23:16];
         2'd3: ld_byte = mem_rdata_i[31:24];
      endcase
      ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      unique case (f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = mem_rdata_i;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      fault_d     = 1'b0;
      f3_d        = f3_q;
      off_d       = off_q;
      rd_d        = rd_q;
      unique case (state_q)
         StIdle: begin
            if (ex_valid_i) begin
               if (!ex_load_i && !ex_store_i) begin
                  wr_en_d   = (ex_rd_i != 5'd0);
                  wr_addr_d = ex_rd_i;
                  wr_data_d = ex_result_i;
               end else if (legal && aligned) begin
                  state_d     = StWait;
                  mem_req_d   = 1'b1;
                  mem_we_d    = ex_store_i;
                  mem_addr_d  = {ex_result_i[XLEN-1:2], 2'b00};
                  mem_wdata_d = ex_store_i ? st_wdata : '0;
                  mem_wstrb_d = ex_store_i ? st_wstrb : 4'b0000;
                  f3_d        = ex_funct3_i;
                  off_d       = ex_result_i[1:0];
                  rd_d        = ex_rd_i;
               end else begin
                  fault_d = 1'b1;
               end
            end
         end
         StWait: begin
            if (mem_ack_i) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  wr_en_d   = (rd_q != 5'd0);
                  wr_addr_d = rd_q;
                  wr_data_d = ld_data;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= 4'b0000;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= 5'd0;
         wr_data_q   <= '0;
         fault_q     <= 1'b0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         rd_q        <= 5'd0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         fault_q     <= fault_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         rd_q        <= rd_d;
      end
   end

   assign ex_ready_o        = (state_q == StIdle);
   assign pause_o           = (state_q == StWait);
   assign mem_req_o         = mem_req_q;
   assign mem_we_o          = mem_we_q;
   assign mem_addr_o        = mem_addr_q;
   assign mem_wdata_o       = mem_wdata_q;
   assign mem_wstrb_o       = mem_wstrb_q;
   assign regs_write_en_o   = wr_en_q;
   assign regs_write_addr_o = wr_addr_q;
   assign regs_in_o         = wr_data_q;
   assign fault_o           = fault_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus random ops checked against a byte-level reference model.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_ready, ex_load = 1'b0, ex_store = 1'b0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic [31:0] ex_result = '0, ex_wdata = '0;
   logic [4:0]  ex_rd = '0;
   logic        mem_req, mem_we, mem_ack = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_wstrb;
   logic        regs_write_en, pause, fault;
   logic [4:0]  regs_write_addr;
   logic [31:0] regs_in;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lsu #(.XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
      .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_funct3_i(ex_funct3),
      .ex_result_i(ex_result), .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
      .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
      .regs_write_en_o(regs_write_en), .regs_write_addr_o(regs_write_addr),
      .regs_in_o(regs_in), .pause_o(pause), .fault_o(fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: access size in bytes, legality, lanes and load extraction
   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit is_fault(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr);
      bit ok;
      if (ld && st) return 1'b1;
      ok = ld ? (f3 inside {0, 1, 2, 4, 5}) : (f3 < 3);
      if (!ok) return 1'b1;
      return (addr % nbytes(f3)) != 0;
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] s = '0;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + nbytes(f3)) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] e;
      for (int i = 0; i < 4; i++) e[8*i +: 8] = wd[8*(i % nbytes(f3)) +: 8];
      return e;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
      int nb = nbytes(f3);
      logic [31:0] v = rd >> (8 * off);
      logic [31:0] mask;
      if (nb == 4) return rd;
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*nb-1]) v = v | ~mask;
      return v;
   endfunction

   // Issue one op, complete it with w wait states if it reaches the bus, and check everything
   task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int w);
      int pcount = 0;
      bit memop = ld || st;
      bit flt = memop && is_fault(ld, st, f3, res);
      @(negedge clk);
      chk("ready_before", {31'd0, ex_ready}, 32'd1);
      ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
      ex_result = res; ex_wdata = wd; ex_rd = rd;
      @(negedge clk);
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
      if (flt) begin
         chk("fault_hi", {31'd0, fault}, 32'd1);
         chk("fault_noreq", {31'd0, mem_req}, 32'd0);
         chk("fault_nowb", {31'd0, regs_write_en}, 32'd0);
         chk("fault_ready", {31'd0, ex_ready}, 32'd1);
         @(negedge clk);
         chk("fault_pulse", {31'd0, fault}, 32'd0);
      end else if (!memop) begin
         chk("alu_we", {31'd0, regs_write_en}, {31'd0, rd != 5'd0});
         if (rd != 5'd0) begin
            chk("alu_addr", {27'd0, regs_write_addr}, {27'd0, rd});
            chk("alu_data", regs_in, res);
         end
         chk("alu_noreq", {31'd0, mem_req}, 32'd0);
      end else begin
         chk("req", {31'd0, mem_req}, 32'd1);
         chk("we", {31'd0, mem_we}, {31'd0, st});
         chk("addr", mem_addr, res & 32'hFFFF_FFFC);
         chk("wstrb", {28'd0, mem_wstrb}, st ? {28'd0, exp_strb(f3, res[1:0])} : 32'd0);
         if (st) chk("wdata", mem_wdata, exp_wdata(f3, wd));
         chk("nofault", {31'd0, fault}, 32'd0);
         for (int i = 0; i < w; i++) begin
            if (pause) pcount++;
            chk("req_hold", {31'd0, mem_req}, 32'd1);
            chk("addr_hold", mem_addr, res & 32'hFFFF_FFFC);
            chk("ready_lo", {31'd0, ex_ready}, 32'd0);
            @(negedge clk);
         end
         if (pause) pcount++;
         mem_ack = 1'b1; mem_rdata = rdata;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = $urandom;
         chk("pause_cycles", pcount, w + 1);
         chk("req_drop", {31'd0, mem_req}, 32'd0);
         chk("pause_lo", {31'd0, pause}, 32'd0);
         chk("wb_en", {31'd0, regs_write_en}, {31'd0, ld && rd != 5'd0});
         if (ld && rd != 5'd0) begin
            chk("wb_addr", {27'd0, regs_write_addr}, {27'd0, rd});
            chk("wb_data", regs_in, exp_load(f3, res[1:0], rdata));
         end
      end
   endtask

   initial begin
      #12;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_pause", {31'd0, pause}, 32'd0);
      chk("rst_outs", {mem_we, fault, regs_write_en, mem_wstrb}, 32'd0);
      chk("rst_addr", mem_addr | mem_wdata | regs_in | {27'd0, regs_write_addr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(0, 0, 3'd0, 32'h0000_002A, 32'd0, 5'd5, 32'd0, 0);            // ALU
      do_op(1, 0, 3'b000, 32'h0000_0103, 32'd0, 5'd9, 32'h8000_0000, 3);  // LB
      do_op(1, 0, 3'b100, 32'h0000_0103, 32'd0, 5'd9, 32'h8000_0000, 3);  // LBU
      do_op(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd3, 32'd0, 1);  // SH
      do_op(1, 0, 3'b010, 32'h0000_0201, 32'd0, 5'd4, 32'd0, 0);          // misaligned LW
      do_op(1, 0, 3'b010, 32'h0000_0400, 32'd0, 5'd0, 32'hDEAD_BEEF, 2);  // LW rd=0
      do_op(1, 0, 3'b001, 32'h0000_0012, 32'd0, 5'd6, 32'h9ABC_1234, 0);  // LH upper half
      do_op(0, 1, 3'b011, 32'h0000_0010, 32'd1, 5'd1, 32'd0, 0);          // illegal store
      do_op(1, 1, 3'b000, 32'h0000_0010, 32'd1, 5'd1, 32'd0, 0);          // both set
      do_op(0, 1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 5'd0, 32'd0, 0);  // SB

      // Back-to-back ALU ops: one write-back per cycle
      @(negedge clk);
      ex_valid = 1'b1; ex_result = 32'h11; ex_rd = 5'd1;
      @(negedge clk);
      ex_result = 32'h22; ex_rd = 5'd2;
      chk("b2b_first", {regs_write_en, regs_write_addr, regs_in[25:0]}, {1'b1, 5'd1, 26'h11});
      @(negedge clk);
      ex_valid = 1'b0;
      chk("b2b_second", {regs_write_en, regs_write_addr, regs_in[25:0]}, {1'b1, 5'd2, 26'h22});

      // Reset mid-WAIT, then a late ack must be ignored
      @(negedge clk);
      ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010; ex_result = 32'h300; ex_rd = 5'd7;
      @(negedge clk);
      ex_valid = 1'b0; ex_load = 1'b0;
      chk("rw_req", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_req_drop", {31'd0, mem_req}, 32'd0);
      chk("rw_pause", {31'd0, pause}, 32'd0);
      chk("rw_ready", {31'd0, ex_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("rw_late_ack_wb", {31'd0, regs_write_en}, 32'd0);
      chk("rw_late_ack_req", {31'd0, mem_req}, 32'd0);
      chk("rw_idle", {31'd0, ex_ready}, 32'd1);

      for (int n = 0; n < 60; n++) begin
         int kind = $urandom_range(0, 9);
         logic ld = (kind >= 2 && kind <= 5) || kind == 9;
         logic st = (kind >= 6);
         do_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
               $urandom, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
